// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, LSB first, optional parity bit,
// one stop bit. Bit period is derived at run time from CLK_FREQ / baudrate.
// Optional build macro UART_RX_MAJORITY_EN: each bit sample becomes a 2-of-3
// majority vote over three consecutive synchronized samples.
module uart_rx #(
   parameter int CLK_FREQ = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] baudrate,
   input  logic        parity_en,
   input  logic        parity_type,
   input  logic        rx,
   output logic [7:0]  data,
   output logic        valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   localparam logic [31:0] CLK_FREQ_W = 32'(CLK_FREQ);

   // Expected parity bit: even -> XOR of data, odd -> its complement.
   function automatic logic exp_parity(input logic [7:0] d, input logic even);
      logic p;
      p = ^d;
      return even ? p : ~p;
   endfunction

`ifdef UART_RX_MAJORITY_EN
   // 2-of-3 majority vote.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
`endif

   state_t      state_r, state_next_s;
   logic        rx_meta_r, rx_sync_r;
   logic        bit_s;
   logic [1:0]  fill_r;
   logic        armed_r;
   logic [31:0] div_s, div_r, half_r, cnt_r, target_s;
   logic        div_ok_s, tick_s;
   logic        par_en_r, par_type_r;
   logic [2:0]  bit_cnt_r;
   logic [7:0]  shift_r;
   logic        par_err_acc_r;
   logic        go_s, shift_en_s, par_smp_s, done_s;
   logic [7:0]  data_r;
   logic        valid_r, parity_err_r, frame_err_r, busy_r;

   // Two-flop synchronizer for the asynchronous serial line (idles high).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic rx_d1_r, rx_d2_r;

   // Delay taps so the vote is centred on rx_d1_r (points -1, 0, +1).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_d1_r <= 1'b1;
         rx_d2_r <= 1'b1;
      end else begin
         rx_d1_r <= rx_sync_r;
         rx_d2_r <= rx_d1_r;
      end
   end

   // Voted bit value used at every sample point.
   always_comb begin
      bit_s = maj3(rx_d2_r, rx_d1_r, rx_sync_r);
   end
`else
   // Single sample of the synchronized line at the sample point.
   always_comb begin
      bit_s = rx_sync_r;
   end
`endif

   // After reset the line must first be seen high through a settled
   // synchronizer, so a frame already in flight is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_r  <= 2'd0;
         armed_r <= 1'b0;
      end else begin
         if (fill_r != 2'd2) begin
            fill_r <= fill_r + 2'd1;
         end else begin
            fill_r <= fill_r;
         end
         armed_r <= armed_r | ((fill_r == 2'd2) & rx_sync_r);
      end
   end

   // Bit period from the live baudrate; zero rate or too-short periods disable reception.
   always_comb begin
      if (baudrate == 32'd0) begin
         div_s = 32'd0;
      end else begin
         div_s = CLK_FREQ_W / baudrate;
      end
      div_ok_s = (div_s >= 32'd4);
      target_s = (state_r == S_START) ? half_r : div_r;
      tick_s   = (cnt_r == target_s);
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_next_s = state_r;
      go_s         = 1'b0;
      shift_en_s   = 1'b0;
      par_smp_s    = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (armed_r && !rx_sync_r && div_ok_s) begin
               state_next_s = S_START;
               go_s         = 1'b1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_START: begin
            if (tick_s) begin
               state_next_s = bit_s ? S_IDLE : S_DATA;
            end else begin
               state_next_s = S_START;
            end
         end
         S_DATA: begin
            if (tick_s) begin
               shift_en_s = 1'b1;
               if (bit_cnt_r == 3'd7) begin
                  state_next_s = par_en_r ? S_PARITY : S_STOP;
               end else begin
                  state_next_s = S_DATA;
               end
            end else begin
               state_next_s = S_DATA;
            end
         end
         S_PARITY: begin
            if (tick_s) begin
               par_smp_s    = 1'b1;
               state_next_s = S_STOP;
            end else begin
               state_next_s = S_PARITY;
            end
         end
         S_STOP: begin
            if (tick_s) begin
               done_s       = 1'b1;
               state_next_s = bit_s ? S_IDLE : S_WAIT_HIGH;
            end else begin
               state_next_s = S_STOP;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_sync_r) begin
               state_next_s = S_IDLE;
            end else begin
               state_next_s = S_WAIT_HIGH;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Frame configuration is captured only while idle, so mid-frame changes wait.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_r      <= 32'd0;
         half_r     <= 32'd0;
         par_en_r   <= 1'b0;
         par_type_r <= 1'b0;
      end else if (state_r == S_IDLE) begin
         div_r      <= div_s;
         half_r     <= div_s >> 1;
         par_en_r   <= parity_en;
         par_type_r <= parity_type;
      end else begin
         div_r      <= div_r;
         half_r     <= half_r;
         par_en_r   <= par_en_r;
         par_type_r <= par_type_r;
      end
   end

   // Sample-point counter: HALF cycles to the start-bit middle, then DIV per bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= 32'd0;
      end else if (go_s) begin
         cnt_r <= 32'd1;
      end else if (state_r == S_IDLE || state_r == S_WAIT_HIGH) begin
         cnt_r <= 32'd0;
      end else if (tick_s) begin
         cnt_r <= 32'd1;
      end else begin
         cnt_r <= cnt_r + 32'd1;
      end
   end

   // Data shifter, bit counter and parity check accumulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_r     <= 3'd0;
         shift_r       <= 8'h00;
         par_err_acc_r <= 1'b0;
      end else if (go_s) begin
         bit_cnt_r     <= 3'd0;
         shift_r       <= 8'h00;
         par_err_acc_r <= 1'b0;
      end else begin
         if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            shift_r   <= {bit_s, shift_r[7:1]};
         end else begin
            bit_cnt_r <= bit_cnt_r;
            shift_r   <= shift_r;
         end
         if (par_smp_s) begin
            par_err_acc_r <= (bit_s != exp_parity(shift_r, par_type_r));
         end else begin
            par_err_acc_r <= par_err_acc_r;
         end
      end
   end

   // Registered outputs: result published the cycle after the stop-bit sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r       <= 8'h00;
         valid_r      <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         valid_r <= done_s;
         busy_r  <= (state_next_s != S_IDLE);
         if (done_s) begin
            data_r       <= shift_r;
            parity_err_r <= par_err_acc_r;
            frame_err_r  <= ~bit_s;
         end else begin
            data_r       <= data_r;
            parity_err_r <= parity_err_r;
            frame_err_r  <= frame_err_r;
         end
      end
   end

   assign data       = data_r;
   assign valid      = valid_r;
   assign parity_err = parity_err_r;
   assign frame_err  = frame_err_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed expected results for uart_rx.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] baudrate;
   logic        parity_en;
   logic        parity_type;
   logic        rx;
   logic [7:0]  data;
   logic        valid;
   logic        parity_err;
   logic        frame_err;
   logic        busy;

   int          n_vec = 0;
   int          n_err = 0;
   int          valid_cnt = 0;
   logic [7:0]  last_data = 8'h00;
   logic        last_perr = 1'b0;
   logic        last_ferr = 1'b0;
   logic [7:0]  rx_q[$];

   localparam int DIV_SLOW = 2604;   // 25 MHz / 9600
   localparam int DIV_FAST = 100;    // 25 MHz / 250000

   always #5 clk = ~clk;

   uart_rx #(.CLK_FREQ(25000000)) dut (
      .clk        (clk),
      .rst        (rst),
      .baudrate   (baudrate),
      .parity_en  (parity_en),
      .parity_type(parity_type),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // Record every cycle valid is high, away from the active edge.
   always @(negedge clk) begin
      if (rst && valid) begin
         valid_cnt = valid_cnt + 1;
         last_data = data;
         last_perr = parity_err;
         last_ferr = frame_err;
         rx_q.push_back(data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic line_bit(input logic v, input int cycles);
      rx = v;
      repeat (cycles) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit,
                             input logic stop, input int div);
      line_bit(1'b0, div);
      for (int i = 0; i < 8; i++) line_bit(b[i], div);
      if (pen) line_bit(pbit, div);
      line_bit(stop, div);
   endtask

   initial begin
      int v0;
      int qs;
      logic [7:0] b;

      rst = 1'b0; rx = 1'b1; baudrate = 32'd9600; parity_en = 1'b1; parity_type = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_data",  {24'd0, data}, 32'h00);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_perr",  {31'd0, parity_err}, 32'd0);
      check("rst_ferr",  {31'd0, frame_err}, 32'd0);
      rst = 1'b1;
      line_bit(1'b1, 10);

      // 0x6D has five ones: even parity bit 1 is correct.
      v0 = valid_cnt;
      send_frame(8'h6D, 1'b1, 1'b1, 1'b1, DIV_SLOW);
      line_bit(1'b1, 50);
      check("par_ok_cnt",  32'(valid_cnt), 32'(v0 + 1));
      check("par_ok_data", {24'd0, last_data}, 32'h6D);
      check("par_ok_perr", {31'd0, last_perr}, 32'd0);
      check("par_ok_ferr", {31'd0, last_ferr}, 32'd0);
      check("par_ok_busy", {31'd0, busy}, 32'd0);

      // Low pulse shorter than half a bit: false start.
      v0 = valid_cnt;
      line_bit(1'b0, 1000);
      line_bit(1'b1, 3000);
      check("glitch_cnt",  32'(valid_cnt), 32'(v0));
      check("glitch_busy", {31'd0, busy}, 32'd0);

      baudrate = 32'd250000;
      line_bit(1'b1, 20);

      v0 = valid_cnt;
      send_frame(8'h6D, 1'b1, 1'b0, 1'b1, DIV_FAST);
      line_bit(1'b1, 20);
      check("par_bad_cnt",  32'(valid_cnt), 32'(v0 + 1));
      check("par_bad_data", {24'd0, last_data}, 32'h6D);
      check("par_bad_perr", {31'd0, last_perr}, 32'd1);

      parity_en = 1'b0;
      line_bit(1'b1, 5);
      v0 = valid_cnt;
      send_frame(8'h6D, 1'b0, 1'b0, 1'b1, DIV_FAST);
      line_bit(1'b1, 20);
      check("nopar_cnt",  32'(valid_cnt), 32'(v0 + 1));
      check("nopar_data", {24'd0, last_data}, 32'h6D);
      check("nopar_perr", {31'd0, last_perr}, 32'd0);

      // Odd parity: 0x6D needs parity bit 0.
      parity_en = 1'b1; parity_type = 1'b0;
      line_bit(1'b1, 5);
      send_frame(8'h6D, 1'b1, 1'b0, 1'b1, DIV_FAST);
      line_bit(1'b1, 20);
      check("odd_perr", {31'd0, last_perr}, 32'd0);
      parity_type = 1'b1; parity_en = 1'b0;
      line_bit(1'b1, 5);

      // Stop bit 0 followed by a 20-bit break.
      v0 = valid_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, DIV_FAST);
      line_bit(1'b0, 20 * DIV_FAST);
      check("brk_cnt",  32'(valid_cnt), 32'(v0 + 1));
      check("brk_data", {24'd0, last_data}, 32'hA5);
      check("brk_ferr", {31'd0, last_ferr}, 32'd1);
      check("brk_busy_low", {31'd0, busy}, 32'd1);
      line_bit(1'b1, 6);
      @(negedge clk);
      check("brk_busy_rel", {31'd0, busy}, 32'd0);
      line_bit(1'b1, 200);
      check("brk_no_more", 32'(valid_cnt), 32'(v0 + 1));

      // Back-to-back frames, no idle gap.
      v0 = valid_cnt;
      qs = rx_q.size();
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, DIV_FAST);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, DIV_FAST);
      line_bit(1'b1, 20);
      check("b2b_cnt", 32'(valid_cnt), 32'(v0 + 2));
      if (rx_q.size() >= qs + 2) begin
         check("b2b_first",  {24'd0, rx_q[qs]},     32'h00);
         check("b2b_second", {24'd0, rx_q[qs + 1]}, 32'hFF);
         check("b2b_ferr",   {31'd0, last_ferr},    32'd0);
      end

      // Reset in the middle of data bit 3 of a third frame.
      v0 = valid_cnt;
      b = 8'h5A;
      line_bit(1'b0, DIV_FAST);
      for (int i = 0; i < 3; i++) line_bit(b[i], DIV_FAST);
      line_bit(b[3], DIV_FAST / 2);
      rst = 1'b0;
      rx = 1'b0;
      @(negedge clk);
      check("mid_rst_data",  {24'd0, data}, 32'h00);
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_busy",  {31'd0, busy}, 32'd0);
      check("mid_rst_ferr",  {31'd0, frame_err}, 32'd0);
      line_bit(1'b0, 5);
      rst = 1'b1;
      line_bit(1'b0, 300);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      line_bit(1'b1, 300);
      check("post_rst_cnt", 32'(valid_cnt), 32'(v0));

      // Baudrate change after the start bit is ignored for this frame.
      v0 = valid_cnt;
      b = 8'h3C;
      line_bit(1'b0, DIV_FAST);
      baudrate = 32'd9600;
      for (int i = 0; i < 8; i++) line_bit(b[i], DIV_FAST);
      line_bit(1'b1, DIV_FAST);
      line_bit(1'b1, 20);
      check("cfg_hold_cnt",  32'(valid_cnt), 32'(v0 + 1));
      check("cfg_hold_data", {24'd0, last_data}, 32'h3C);
      baudrate = 32'd250000;
      line_bit(1'b1, 20);

`ifdef UART_RX_MAJORITY_EN
      // One-clock high glitch near the middle of data bit 2 of 0x00.
      v0 = valid_cnt;
      line_bit(1'b0, DIV_FAST);
      line_bit(1'b0, DIV_FAST);
      line_bit(1'b0, DIV_FAST);
      line_bit(1'b0, DIV_FAST / 2);
      line_bit(1'b1, 1);
      line_bit(1'b0, DIV_FAST / 2 - 1);
      for (int i = 3; i < 8; i++) line_bit(1'b0, DIV_FAST);
      line_bit(1'b1, DIV_FAST);
      line_bit(1'b1, 20);
      check("maj_cnt",  32'(valid_cnt), 32'(v0 + 1));
      check("maj_data", {24'd0, last_data}, 32'h00);
`endif

      // Zero baudrate: traffic on the line is never received.
      baudrate = 32'd0;
      line_bit(1'b1, 10);
      v0 = valid_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, DIV_FAST);
      line_bit(1'b1, 50);
      check("baud0_cnt",  32'(valid_cnt), 32'(v0));
      check("baud0_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
